ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the single-cycle RV64 core.
- Generates sequential fetch addresses and issues 32-bit reads to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents each instruction, tagged with its PC, to the core over a valid/ready handshake.
- Accepts a redirect (jal/jalr target) from the core, flushing queued and in-flight stale fetches.

Parameters:
- RESET_PC, 64'h0000000080000000, first fetch address after reset.
- DEPTH, 4, FIFO entries; also the cap on buffered plus in-flight fetches (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- redirect_valid  in  1  core requests a fetch redirect this cycle.
- redirect_pc  in  64  redirect target; bits [1:0] ignored (treated as 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  64  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, never back-pressured.
- imem_rsp_data  in  32  fetched instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  core consumes the head.
- inst  out  32  head instruction.
- inst_pc  out  64  PC of the head instruction.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, fifo_count=0, inflight=0, drop_cnt=0. Outputs: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC, inst/inst_pc=0. Reset mid-operation discards everything; responses to pre-reset requests are the memory's responsibility.
- imem_req_valid = ~redirect_valid & (fifo_count + inflight < DEPTH). imem_req_addr = fetch_pc. imem_req_valid is held stable until accepted unless a redirect occurs.
- Request handshake (valid & ready): fetch_pc += 4 (64-bit wrap), inflight += 1.
- Response arrival: inflight -= 1.
  - If drop_cnt>0, drop_cnt -= 1 and the data is discarded.
  - Else push {rsp_pc, imem_rsp_data} into the FIFO and rsp_pc += 4.
- Output: inst_valid = fifo_count != 0; inst/inst_pc come from the FIFO head (registered storage, no combinational path from imem_rsp_*). Pop on inst_valid & inst_ready.
- Latency: a response arriving in cycle N is visible on inst_valid in cycle N+1.
- Simultaneous push and pop: fifo_count is unchanged, and pointer wrap is modulo DEPTH.
- Full: credit check guarantees a response always has a slot; a push into a full FIFO is impossible by construction and may be asserted against.
- Redirect (redirect_valid=1), with priority over all other events that cycle:
  - FIFO flushed: fifo_count=0, pointers reset; any pop that cycle is ignored.
  - fetch_pc and rsp_pc set to {redirect_pc[63:2],2'b00}.
  - No request is issued that cycle (imem_req_valid gated low).
  - drop_cnt = inflight after this cycle's response is accounted for. A same-cycle response is discarded regardless of the old drop_cnt.
  - Back-to-back redirects: each recomputes drop_cnt from current inflight; the last target wins.
- Counters: inflight and drop_cnt are clog2(DEPTH)+1 bits wide. drop_cnt ≤ inflight always.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008. Core sees inst_pc in the same order with matching data, first inst_valid 2 cycles after the first request.
- inst_ready=0, memory always ready -> exactly DEPTH=4 requests issued, then imem_req_valid=0. Raise inst_ready -> 4 pops, and requests resume.
- Redirect to 0x80000103 with 2 requests in flight -> both responses dropped. Next request addr=0x80000100, and the first delivered inst_pc=0x80000100.
- Redirect in the same cycle as a response and as an inst handshake -> response discarded, FIFO empty next cycle, no PC duplicated or skipped.
- imem_req_ready held low 5 cycles -> imem_req_valid and imem_req_addr stable throughout; exactly one fetch of that address after acceptance.
- Assert rst mid-stream with FIFO holding 3 entries -> inst_valid=0 immediately (async); after release, first request is 0x80000000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: sequential word fetches to imem, in-order response FIFO, PC-tagged
// delivery to the core, and redirect handling that flushes queued and in-flight stale fetches.
// Latency: a response in cycle N is presented on inst_valid in cycle N+1; requests stall when
// buffered plus in-flight fetches reach DEPTH, so a response always finds a free FIFO slot.
// Ports: clk/rst (async active-low); redirect_valid/redirect_pc from core;
//   imem_req_valid/ready/addr request channel; imem_rsp_valid/data response (never stalled);
//   inst_valid/ready/inst/inst_pc towards the core.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [31:0]   data_q [DEPTH];
  logic [63:0]   pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   occupancy;
  logic [CW-1:0] inflight_nxt;
  logic [63:0]   redirect_tgt;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          unused_pc_bits;

  assign redirect_tgt   = {redirect_pc[63:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Credits cover both buffered entries and outstanding fetches, so the sum needs one extra bit.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight};
  // Holding rst low also forces the request low while the async reset is applied.
  assign imem_req_valid = rst & ~redirect_valid & (occupancy < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Redirect outranks everything: a same-cycle response is dropped and the head is not consumed.
  assign push = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);
  assign pop  = inst_valid & inst_ready & ~redirect_valid;

  assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

  assign inst_valid = (fifo_count != '0);
  assign inst       = data_q[rd_ptr];
  assign inst_pc    = pc_q[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      rsp_pc     <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc   <= redirect_tgt;
        rsp_pc     <= redirect_tgt;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
        // Everything still outstanding after this cycle belongs to the old stream.
        drop_cnt   <= inflight_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          data_q[wr_ptr] <= imem_rsp_data;
          pc_q[wr_ptr]   <= rsp_pc;
          wr_ptr         <= wr_ptr + PW'(1);
          rsp_pc         <= rsp_pc + 64'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // The credit check makes a push into a full FIFO unreachable.
  assert property (@(posedge clk) disable iff (!rst) !(push && (fifo_count == CW'(DEPTH))));
  assert property (@(posedge clk) disable iff (!rst) (drop_cnt <= inflight));

endmodule
